// File: rtl/ddc_frame_buffer.sv
// ddc_frame_buffer: collects detector samples into WORDS-word frames, stamps
// each frame with PPS-relative time and PPS count, and holds the completed
// frame for the HPS until it toggles hps_read_bit.
// Optional feature macro: DDC_FRAME_HEADER_EN (word 0 becomes a header word).
module ddc_frame_buffer #(
    parameter int unsigned WORDS  = 32,
    parameter int unsigned TIME_W = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [31:0]           sample_data,
    input  logic                  pps_in,
    input  logic                  hps_read_bit,
    output logic [32*WORDS-1:0]   frame_data,
    output logic [TIME_W-1:0]     ddc_time_out,
    output logic [31:0]           pps_count_out,
    output logic                  frame_ready,
    output logic [15:0]           drop_count
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef DDC_FRAME_HEADER_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state_q, state_d;

    logic              pps_s1, pps_s2, pps_s3;
    logic              pps_evt;
    logic [TIME_W-1:0] time_cnt;
    logic [31:0]       pps_cnt;

    logic              hps_q;
    logic              ack;

    logic [IDX_W-1:0]  widx;
    logic [31:0]       fill [WORDS];
    logic [TIME_W-1:0] stamp_time;
    logic [31:0]       stamp_pps;
    logic              complete;
    logic              commit;
    logic [32*WORDS-1:0] commit_frame;

`ifdef DDC_FRAME_HEADER_EN
    logic [7:0]        seq;
`endif

    // PPS synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            pps_s1 <= 1'b0;
            pps_s2 <= 1'b0;
            pps_s3 <= 1'b0;
        end else begin
            pps_s1 <= pps_in;
            pps_s2 <= pps_s1;
            pps_s3 <= pps_s2;
        end
    end

    assign pps_evt = pps_s2 & ~pps_s3;

    // Sub-second counter (saturating) and wrapping PPS counter
    always_ff @(posedge clk) begin
        if (reset) begin
            time_cnt <= '0;
            pps_cnt  <= '0;
        end else begin
            if (pps_evt) begin
                time_cnt <= '0;
                pps_cnt  <= pps_cnt + 32'd1;
            end else if (time_cnt != '1) begin
                time_cnt <= time_cnt + 1'b1;
            end
        end
    end

    // Ack history; loaded from the live input during reset to avoid a false ack
    always_ff @(posedge clk) begin
        if (reset) begin
            hps_q <= hps_read_bit;
        end else begin
            hps_q <= hps_read_bit;
        end
    end

    assign ack      = hps_read_bit ^ hps_q;
    assign complete = sample_valid && (widx == LAST_IDX);
    assign commit   = complete && ((state_q == EMPTY) || ack);

    // Fill-side word index and stamp capture on the first sample of a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            widx       <= FIRST_IDX;
            stamp_time <= '0;
            stamp_pps  <= '0;
        end else if (sample_valid) begin
            widx <= complete ? FIRST_IDX : widx + 1'b1;
            if (widx == FIRST_IDX) begin
                stamp_time <= time_cnt;
                stamp_pps  <= pps_cnt;
            end
        end
    end

    // Fill buffer storage; every word is rewritten before it can be committed
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            fill[widx] <= sample_data;
        end
    end

    // Assemble the frame to commit: stored words plus the word arriving now
    always_comb begin
        commit_frame = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            commit_frame[32*k +: 32] = fill[k];
        end
        commit_frame[32*(WORDS-1) +: 32] = sample_data;
`ifdef DDC_FRAME_HEADER_EN
        commit_frame[31:0] = {8'hA5, seq, drop_count};
`endif
    end

    // Held-frame registers, updated only on commit
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data    <= '0;
            ddc_time_out  <= '0;
            pps_count_out <= '0;
        end else if (commit) begin
            frame_data    <= commit_frame;
            ddc_time_out  <= stamp_time;
            pps_count_out <= stamp_pps;
        end
    end

    // Saturating count of frames discarded because the held frame was unread
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (complete && !commit && (drop_count != '1)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

`ifdef DDC_FRAME_HEADER_EN
    // Wrapping sequence number of committed frames
    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= '0;
        end else if (commit) begin
            seq <= seq + 8'd1;
        end
    end
`endif

    // Held-side state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Held-side next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (commit) state_d = FULL;
            FULL: begin
                if (commit)   state_d = FULL;
                else if (ack) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Held-side outputs
    always_comb begin
        frame_ready = 1'b0;
        if (state_q == FULL) frame_ready = 1'b1;
    end

endmodule

// File: tb/tb_ddc_frame_buffer.sv
// tb_ddc_frame_buffer: directed bench for ddc_frame_buffer.
// Builds with or without DDC_FRAME_HEADER_EN; expected values adapt to it.
`ifdef DDC_FRAME_HEADER_EN
`define TB_W0(b, s) {8'hA5, 8'(s), 16'h0000}
`else
`define TB_W0(b, s) (b)
`endif

module tb_ddc_frame_buffer;

    localparam int unsigned WORDS  = 32;
    localparam int unsigned TIME_W = 26;
`ifdef DDC_FRAME_HEADER_EN
    localparam int unsigned OFS = 1;
`else
    localparam int unsigned OFS = 0;
`endif
    localparam int unsigned NS = WORDS - OFS;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic [31:0]         sample_data;
    logic                pps_in;
    logic                hps_read_bit;
    logic [32*WORDS-1:0] frame_data;
    logic [TIME_W-1:0]   ddc_time_out;
    logic [31:0]         pps_count_out;
    logic                frame_ready;
    logic [15:0]         drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    ddc_frame_buffer #(.WORDS(WORDS), .TIME_W(TIME_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .pps_in        (pps_in),
        .hps_read_bit  (hps_read_bit),
        .frame_data    (frame_data),
        .ddc_time_out  (ddc_time_out),
        .pps_count_out (pps_count_out),
        .frame_ready   (frame_ready),
        .drop_count    (drop_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int unsigned k);
        return frame_data[32*k +: 32];
    endfunction

    // Sample words 1 and WORDS-1 of the held frame against a frame starting at base
    task automatic check_frame(input string tag, input logic [31:0] base);
        check({tag, ".w1"},  word(1),        base + 32'(1 - OFS));
        check({tag, ".wN"},  word(WORDS-1),  base + 32'(WORDS - 1 - OFS));
    endtask

    // Drive one full frame starting at a negedge; returns at the negedge after
    // the last word, so the commit is already visible. Optionally toggles the
    // ack in the same cycle as the final word.
    task automatic send_frame(input logic [31:0] base, input bit ack_last);
        for (int i = 0; i < int'(NS); i++) begin
            sample_valid = 1'b1;
            sample_data  = base + 32'(i);
            if (ack_last && i == int'(NS) - 1) hps_read_bit = ~hps_read_bit;
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        pps_in       = 1'b0;
        hps_read_bit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst.ready", 32'(frame_ready), 32'd0);
        check("rst.drop",  32'(drop_count),  32'd0);
        check("rst.w0",    word(0),          32'd0);
        check("rst.time",  32'(ddc_time_out), 32'd0);
        check("rst.pps",   pps_count_out,    32'd0);

        // First frame, no PPS yet
        send_frame(32'h100, 1'b0);
        check("f1.ready", 32'(frame_ready), 32'd1);
        check("f1.w0",    word(0), `TB_W0(32'h100, 0));
        check_frame("f1", 32'h100);
        check("f1.drop",  32'(drop_count), 32'd0);
        check("f1.pps",   pps_count_out, 32'd0);

        // Ack drops frame_ready after one cycle, contents retained
        hps_read_bit = ~hps_read_bit;
        @(negedge clk);
        check("ack.ready", 32'(frame_ready), 32'd0);
        check("ack.w0",    word(0), `TB_W0(32'h100, 0));

        // PPS rise, 1000 idle cycles, then a frame
        pps_in = 1'b1;
        repeat (1000) @(negedge clk);
        send_frame(32'h300, 1'b0);
        check("pps.ready", 32'(frame_ready), 32'd1);
        check("pps.count", pps_count_out, 32'd1);
        check("pps.time",  32'(ddc_time_out), 32'd997);
        check("pps.w0",    word(0), `TB_W0(32'h300, 1));
        pps_in = 1'b0;
        hps_read_bit = ~hps_read_bit;
        @(negedge clk);
        check("pps.ackready", 32'(frame_ready), 32'd0);

        // Two back-to-back frames without ack: second is dropped
        send_frame(32'hA00, 1'b0);
        send_frame(32'hB00, 1'b0);
        check("drop.ready", 32'(frame_ready), 32'd1);
        check("drop.count", 32'(drop_count), 32'd1);
        check("drop.w0",    word(0), `TB_W0(32'hA00, 2));
        check_frame("drop", 32'hA00);

        // Fresh reset, then ack coinciding with second frame completion
        do_reset();
        check("rst2.ready", 32'(frame_ready), 32'd0);
        check("rst2.drop",  32'(drop_count),  32'd0);
        send_frame(32'hA00, 1'b0);
        send_frame(32'hB00, 1'b1);
        check("swap.ready", 32'(frame_ready), 32'd1);
        check("swap.drop",  32'(drop_count),  32'd0);
        check("swap.w0",    word(0), `TB_W0(32'hB00, 1));
        check_frame("swap", 32'hB00);
        @(negedge clk);
        check("swap.hold", 32'(frame_ready), 32'd1);

        // Reset in the middle of a frame discards the partial words
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'hC00 + 32'(i);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        do_reset();
        check("mid.ready", 32'(frame_ready), 32'd0);
        send_frame(32'h200, 1'b0);
        check("mid.ready2", 32'(frame_ready), 32'd1);
        check("mid.w0",     word(0), `TB_W0(32'h200, 0));
        check("mid.w9",     word(9), 32'h200 + 32'(9 - OFS));
        check_frame("mid", 32'h200);
        check("mid.drop",   32'(drop_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddc_frame_buffer.md
# ddc_frame_buffer

Capture stage directly upstream of the HPS PIO bank: collects a stream of 32-bit detector samples into 32-word frames, stamps each frame with the PPS-referenced time and the PPS count, and presents the completed frame on the `ddc_data_*` / `ddc_time_out` / `pps_count_out` exports. It implements the frame-level handshake with the HPS through `hps_read_bit`. A fill-side buffer keeps accepting samples while the HPS reads the held frame; frames that complete while the held frame is unread are dropped and counted.

## Interface
- `WORDS`, 32: samples per frame; one per `ddc_data_N` export.
- `TIME_W`, 26: width of the sub-second clock counter.
- `clk`  in  1: system clock (50 MHz, same domain as the HPS PIO bank).
- `reset`  in  1: synchronous, active-high reset.
- `sample_valid`  in  1: `sample_data` valid this cycle.
- `sample_data`  in  32: detector sample word.
- `pps_in`  in  1: raw GPS PPS, asynchronous.
- `hps_read_bit`  in  1: HPS acknowledge; a toggle means the held frame has been consumed.
- `frame_data`  out  32*WORDS: held frame; word N at `[32N+31:32N]` drives `ddc_data_N`.
- `ddc_time_out`  out  TIME_W: clock count since last PPS at the held frame's first sample.
- `pps_count_out`  out  32: PPS count at the held frame's first sample.
- `frame_ready`  out  1: held frame valid and not yet acknowledged.
- `drop_count`  out  16: frames dropped since reset; saturating.

## Operation
- **PPS path:**
  - `pps_in` passes through a 2-flop synchronizer; the rising edge of the synchronized signal is `pps_evt`, 1 cycle wide.
  - `time_cnt` (TIME_W): clears to 0 on `pps_evt`; otherwise increments, saturating at all-ones.
  - `pps_cnt` (32): increments on `pps_evt` and wraps.
- **Fill side:**
  - Word index `widx` runs 0..WORDS-1; each `sample_valid` writes `sample_data` into `fill[widx]`.
  - On a write with `widx == 0`, `time_cnt` and `pps_cnt` are latched as the frame stamp, using the values present that same cycle.
  - Writing `widx == WORDS-1` completes the frame and `widx` wraps to 0.
- **Commit.** On frame completion in cycle T:
  - The frame commits if `frame_ready == 0`, or if an ack is detected in cycle T.
  - On commit, next cycle: `frame_data` = full frame (including the word written in T), `ddc_time_out` / `pps_count_out` = stamp, `frame_ready` = 1.
  - Otherwise the frame is discarded, `drop_count` increments (saturating at 0xFFFF), and the held frame is unchanged.
- **Ack:**
  - `ack` = `hps_read_bit` differs from its 1-cycle registered copy (either edge).
  - Ack with no commit in the same cycle: `frame_ready` falls next cycle; held outputs are retained.
  - Ack while `frame_ready == 0`: ignored.
- **State machine (held side):**
  - EMPTY → FULL on commit.
  - FULL → EMPTY on ack without commit.
  - FULL → FULL on commit with simultaneous ack (new frame replaces old).
  - `frame_ready == (state == FULL)`.
- **Reset:**
  - All outputs go to 0; `widx`, counters, synchronizer and ack history are cleared.
  - The ack history is loaded with the current `hps_read_bit`, so no spurious ack follows reset.
  - A partial frame in progress at reset is discarded.

## Timing
- Sample-to-output latency: 1 cycle after the last word's `sample_valid`.
- Accepts 1 sample per cycle continuously; `sample_valid` has no backpressure.
- PPS: `pps_in` rise → `time_cnt` == 0 after 3 `clk` edges (2 sync + 1 edge detect).
- Ack → `frame_ready` low: 1 cycle after the `hps_read_bit` change.
- The HPS must read all exports between `frame_ready` rising and toggling `hps_read_bit`. Held outputs are stable for that whole interval.

## Configuration
- `DDC_FRAME_HEADER_EN` **defined:**
  - Word 0 of each committed frame is the header `{8'hA5, seq[7:0], drop_count[15:0]}`.
  - `seq` is a wrapping 8-bit count of committed frames, starting at 0 after reset.
  - Each frame holds WORDS-1 samples, in words 1..WORDS-1.
  - The stamp is latched on the first sample, which is stored in word 1.
- **Not defined:** all WORDS words carry samples; no `seq` register exists.

## Test plan
- Reset, then 32 consecutive samples 0x100..0x11F → `frame_ready` = 1 one cycle after the 32nd; `ddc_data_0` = 0x100, `ddc_data_31` = 0x11F; `drop_count` = 0.
- PPS rise, then 1000 idle cycles, then a frame → `pps_count_out` = 1 and `ddc_time_out` = 997 (1000 minus 3-cycle sync latency).
- Two back-to-back frames (0xA.. and 0xB..), no ack → held frame stays 0xA..; `drop_count` = 1; `frame_ready` = 1.
- Toggle `hps_read_bit` in exactly the cycle the 2nd frame completes → held frame = 0xB..; `frame_ready` stays 1; `drop_count` = 0.
- Assert `reset` after 10 words of a frame, then send 32 fresh words 0x200.. → held frame = 0x200..0x21F; no residue from the first 10 words.
- `DDC_FRAME_HEADER_EN` defined, two frames with an ack between them → `ddc_data_0` = 0xA5000000 then 0xA5010000; `ddc_data_1` = the first sample of each frame.
